// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
// The enum encoding is fixed so the state register is a single flop.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted req at or after rr_ptr, wrapping mod NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            found,
  output logic [IW-1:0]   index
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Walk candidates in priority order; the first hit locks found and index.
  always_comb begin
    found  = 1'b0;
    index  = rr_ptr;
    cand_s = rr_ptr;
    hit_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = IW'((int'(rr_ptr) + i) % NREQ);
      hit_s  = req[cand_s] & ~found;
      index  = hit_s ? cand_s : index;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NREQ beat streams into one FIFO write port.
// A grant lasts until the packet's last beat or MAX_BURST beats, whichever comes first.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             beat_total
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_ID     = IW'(NREQ - 1);

  arb_state_e       state_r;
  arb_state_e       state_next_s;
  logic [IW-1:0]    grant_id_r;
  logic [IW-1:0]    rr_ptr_r;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_found_s;
  logic [CW-1:0]    beat_cnt_r;
  logic [15:0]      beat_total_r;
  logic             transfer_s;
  logic             burst_end_s;
  logic [DSIZE-1:0] lane_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane_s[g] = req_data[g*DSIZE +: DSIZE];
  end

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .index  (pick_idx_s)
  );

  // Reset gating keeps the write strobe dead even before the state flop settles.
  assign transfer_s  = (state_r == BURST) & req_valid[grant_id_r] & ~wfull & wrst_n;
  assign burst_end_s = transfer_s &
                       (req_last[grant_id_r] | ((beat_cnt_r + CW'(1)) == BURST_LIMIT));
  assign wdata       = lane_s[grant_id_r];
  assign grant_id    = grant_id_r;
  assign beat_total  = beat_total_r;

  // State register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) state_next_s = BURST;
        else              state_next_s = IDLE;
      end
      BURST: begin
        if (burst_end_s) state_next_s = IDLE;
        else             state_next_s = BURST;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    winc        = 1'b0;
    req_ready   = {NREQ{1'b0}};
    grant_valid = 1'b0;
    case (state_r)
      IDLE: begin
        winc        = 1'b0;
        grant_valid = 1'b0;
      end
      BURST: begin
        winc                  = transfer_s;
        req_ready[grant_id_r] = ~wfull & wrst_n;
        grant_valid           = 1'b1;
      end
      default: begin
        winc        = 1'b0;
        grant_valid = 1'b0;
      end
    endcase
  end

  // Grant capture, per-burst beat count and round-robin pointer update.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      grant_id_r <= {IW{1'b0}};
      rr_ptr_r   <= {IW{1'b0}};
      beat_cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_id_r <= pick_idx_s;
            beat_cnt_r <= {CW{1'b0}};
          end
        end
        BURST: begin
          if (transfer_s) beat_cnt_r <= beat_cnt_r + CW'(1);
          if (burst_end_s) rr_ptr_r <= (grant_id_r == LAST_ID) ? {IW{1'b0}} : grant_id_r + IW'(1);
        end
        default: beat_cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // Lifetime beat counter, wraps naturally at 16 bits.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      beat_total_r <= 16'd0;
    end else if (winc) begin
      beat_total_r <= beat_total_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with default parameters (8/4/8).
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] beat_total;

  int n_cmp = 0;
  int n_err = 0;
  int got;

  fifo_wr_arbiter dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wfull       (wfull),
    .winc        (winc),
    .wdata       (wdata),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_total  (beat_total)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i]        = v;
    req_last[i]         = l;
    req_data[i*8 +: 8]  = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gv"},   32'(grant_valid), 32'd0);
    chk({tag, "_winc"}, 32'(winc),        32'd0);
    chk({tag, "_rdy"},  32'(req_ready),   32'd0);
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] id, input logic [7:0] d);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << id;
    chk({tag, "_gv"},    32'(grant_valid), 32'd1);
    chk({tag, "_gid"},   32'(grant_id),    32'(id));
    chk({tag, "_winc"},  32'(winc),        32'd1);
    chk({tag, "_wdata"}, 32'(wdata),       32'(d));
    chk({tag, "_rdy"},   32'(req_ready),   32'(one_hot));
  endtask

  // Requester 0 streams until n writes are seen, then drops valid after the last one commits.
  task automatic run_writes(input int n, output int seen);
    int budget;
    budget = 0;
    seen   = 0;
    req_valid[0] = 1'b1;
    #1;
    if (winc) seen++;
    while (seen < n && budget < 80000) begin
      cyc();
      budget++;
      if (winc) seen++;
    end
    cyc();
    req_valid[0] = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    wrst_n    = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 32'h0;
    wfull     = 1'b0;

    // Reset: outputs quiet even with every requester asking.
    repeat (2) cyc();
    req_valid = 4'b1111;
    #1;
    chk_idle("rst");
    chk("rst_gid",   32'(grant_id),   32'd0);
    chk("rst_total", 32'(beat_total), 32'd0);
    cyc();
    chk_idle("rst_hold");
    req_valid = 4'b0000;

    // Single requester, three-beat packet.
    set_req(0, 1'b1, 1'b0, 8'h11);
    wrst_n = 1'b1;
    #1;
    chk_idle("t1_idle");
    cyc();               #1; chk_beat("t1_b0", 2'd0, 8'h11);
    cyc(); set_req(0, 1'b1, 1'b0, 8'h22); #1; chk_beat("t1_b1", 2'd0, 8'h22);
    cyc(); set_req(0, 1'b1, 1'b1, 8'h33); #1; chk_beat("t1_b2", 2'd0, 8'h33);
    cyc(); set_req(0, 1'b0, 1'b0, 8'h00); #1; chk_idle("t1_end");
    chk("t1_total", 32'(beat_total), 32'd3);

    // Fresh reset, all four requesters with one-beat packets: 0,1,2,3,0.
    wrst_n = 1'b0;
    cyc();
    wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    #1;
    chk_idle("t2_idle0");
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk_beat($sformatf("t2_g%0d", k), exp_id[k], 8'(8'hA0 + 8'(exp_id[k])));
      cyc();
      if (k == 4) req_valid = 4'b0000;
      #1;
      chk_idle($sformatf("t2_i%0d", k));
    end
    chk("t2_total", 32'(beat_total), 32'd5);

    // Requester 2, ten beats: truncated at 8, re-arbitrated, finishes with 2.
    req_last = 4'b0000;
    set_req(2, 1'b1, 1'b0, 8'h30);
    #1;
    chk_idle("t3_idle");
    for (int k = 0; k < 8; k++) begin
      cyc(); set_req(2, 1'b1, 1'b0, 8'(8'h30 + k)); #1;
      chk_beat($sformatf("t3_b%0d", k), 2'd2, 8'(8'h30 + k));
    end
    cyc(); set_req(2, 1'b1, 1'b0, 8'h38); #1; chk_idle("t3_rearb");
    cyc(); #1; chk_beat("t3_b8", 2'd2, 8'h38);
    cyc(); set_req(2, 1'b1, 1'b1, 8'h39); #1; chk_beat("t3_b9", 2'd2, 8'h39);
    cyc(); set_req(2, 1'b0, 1'b0, 8'h00); #1; chk_idle("t3_end");
    chk("t3_total", 32'(beat_total), 32'd15);

    // Requester 1, six beats with a four-cycle wfull stall after two beats.
    set_req(1, 1'b1, 1'b0, 8'h51);
    #1;
    chk_idle("t4_idle");
    cyc(); #1; chk_beat("t4_b0", 2'd1, 8'h51);
    cyc(); set_req(1, 1'b1, 1'b0, 8'h52); #1; chk_beat("t4_b1", 2'd1, 8'h52);
    cyc(); set_req(1, 1'b1, 1'b0, 8'h53); wfull = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk($sformatf("t4_s%0d_winc", s),  32'(winc),        32'd0);
      chk($sformatf("t4_s%0d_rdy", s),   32'(req_ready),   32'd0);
      chk($sformatf("t4_s%0d_gv", s),    32'(grant_valid), 32'd1);
      chk($sformatf("t4_s%0d_total", s), 32'(beat_total),  32'd17);
      cyc();
    end
    wfull = 1'b0;
    #1; chk_beat("t4_b2", 2'd1, 8'h53);
    cyc(); set_req(1, 1'b1, 1'b0, 8'h54); #1; chk_beat("t4_b3", 2'd1, 8'h54);
    cyc(); set_req(1, 1'b1, 1'b0, 8'h55); #1; chk_beat("t4_b4", 2'd1, 8'h55);
    cyc(); set_req(1, 1'b1, 1'b1, 8'h56); #1; chk_beat("t4_b5", 2'd1, 8'h56);
    cyc(); set_req(1, 1'b0, 1'b0, 8'h00); #1; chk_idle("t4_end");
    chk("t4_total", 32'(beat_total), 32'd21);

    // Requester 3 interrupted by reset after two beats; pointer restarts at 0.
    set_req(3, 1'b1, 1'b0, 8'h61);
    #1;
    chk_idle("t5_idle");
    cyc(); #1; chk_beat("t5_b0", 2'd3, 8'h61);
    cyc(); set_req(3, 1'b1, 1'b0, 8'h62); #1; chk_beat("t5_b1", 2'd3, 8'h62);
    cyc(); set_req(3, 1'b1, 1'b0, 8'h63); #1; chk_beat("t5_b2", 2'd3, 8'h63);
    wrst_n = 1'b0;
    #1;
    chk_idle("t5_rst");
    chk("t5_rst_total", 32'(beat_total), 32'd0);
    chk("t5_rst_gid",   32'(grant_id),   32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    cyc();
    wrst_n = 1'b1;
    #1; chk_idle("t5_rel");
    cyc(); #1; chk_beat("t5_g0", 2'd0, 8'hA0);
    cyc(); req_valid = 4'b0000; #1; chk_idle("t5_end");
    chk("t5_total", 32'(beat_total), 32'd1);

    // beat_total wrap: 65534 writes, then 3 more.
    wrst_n = 1'b0;
    req_last = 4'b0000;
    set_req(0, 1'b0, 1'b0, 8'h77);
    cyc();
    wrst_n = 1'b1;
    run_writes(65534, got);
    chk("t6_pre_cnt",   32'(got),        32'd65534);
    chk("t6_pre_total", 32'(beat_total), 32'd65534);
    run_writes(3, got);
    chk("t6_post_cnt",   32'(got),        32'd3);
    chk("t6_wrap_total", 32'(beat_total), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
